// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the MixColumns FSM encoding.
// Column helpers use the state layout: column c = bits [127-32c -: 32].
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [31:0]  column_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic column_t get_col(input state_t s, input logic [1:0] idx);
        column_t c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    function automatic state_t set_col(input state_t s, input logic [1:0] idx, input column_t c);
        state_t r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq: input state channel and held output channel.
// With MIXCOL_BYPASS_EN defined the input channel also carries in_last.
interface mix_columns_seq_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;
`ifdef MIXCOL_BYPASS_EN
    logic   in_last;

    modport master (
        output in_valid, in_state, in_last, out_ready,
        input  in_ready, out_valid, out_state
    );
    modport slave (
        input  in_valid, in_state, in_last, out_ready,
        output in_ready, out_valid, out_state
    );
`else
    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );
    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
`endif

endinterface

// File: rtl/mix_column_fwd.sv
// Combinational forward MixColumns of one 32-bit column, matrix [02 03 01 01] circulant.
module mix_column_fwd
    import aes_pkg::*;
(
    input  column_t col_i,
    output column_t col_o
);

    logic [7:0] a, b, c, d;

    assign {a, b, c, d} = col_i;

    assign col_o = {
        xtime(a) ^ mul3(b)  ^ c        ^ d,
        a        ^ xtime(b) ^ mul3(c)  ^ d,
        a        ^ b        ^ xtime(c) ^ mul3(d),
        mul3(a)  ^ b        ^ c        ^ xtime(d)
    };

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: COLS_PER_CYCLE columns per BUSY cycle, held valid/ready output.
// Optional MIXCOL_BYPASS_EN adds in_last to pass the state through unmixed with identical timing.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input logic             clk,
    input logic             rst,
    mix_columns_seq_if.slave bus
);

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

    fsm_state_t state_q, state_d;
    logic [1:0] col_cnt_q, col_cnt_d;
    state_t     in_q, res_q, res_d, out_q;
    logic       load_in, load_out;

    column_t    mix_in   [COLS_PER_CYCLE];
    column_t    mix_out  [COLS_PER_CYCLE];
    column_t    mixed    [COLS_PER_CYCLE];
    logic [1:0] grp_idx  [COLS_PER_CYCLE];

`ifdef MIXCOL_BYPASS_EN
    logic last_q;
`endif

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign grp_idx[k] = col_cnt_q + 2'(k);
        assign mix_in[k]  = get_col(in_q, grp_idx[k]);

        mix_column_fwd u_mix (
            .col_i (mix_in[k]),
            .col_o (mix_out[k])
        );

`ifdef MIXCOL_BYPASS_EN
        // Final round skips MixColumns but keeps the same pipeline timing.
        assign mixed[k] = last_q ? mix_in[k] : mix_out[k];
`else
        assign mixed[k] = mix_out[k];
`endif
    end

    always_comb begin
        res_d = res_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            res_d = set_col(res_d, grp_idx[k], mixed[k]);
        end
    end

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        load_in   = 1'b0;
        load_out  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load_in   = 1'b1;
                    col_cnt_d = 2'd0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                col_cnt_d = col_cnt_q + STEP;
                if (col_cnt_q == LAST_GRP) begin
                    load_out = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            in_q      <= '0;
            res_q     <= '0;
            out_q     <= '0;
`ifdef MIXCOL_BYPASS_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            if (load_in) begin
                in_q <= bus.in_state;
`ifdef MIXCOL_BYPASS_EN
                last_q <= bus.in_last;
`endif
            end
            if (state_q == BUSY) begin
                res_q <= res_d;
            end
            // out_state only moves on DONE entry so it stays stable under backpressure.
            if (load_out) begin
                out_q <= res_d;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE) && !rst;
    assign bus.out_state = out_q;

endmodule
